// File: rtl/light_pkg.sv
// Shared lamp codes, controller state encoding and lamp-field width for the multi-way light controller.
// Macro LIGHT_FLASH_EN adds the maintenance FLASH state.
package light_pkg;

   localparam int unsigned LAMP_W = 2;

   typedef enum logic [LAMP_W-1:0] {
      LAMP_RED    = 2'b00,
      LAMP_YELLOW = 2'b01,
      LAMP_GREEN  = 2'b10,
      LAMP_OFF    = 2'b11
   } lamp_e;

   typedef enum logic [1:0] {
      ST_GREEN,
      ST_YELLOW,
      ST_ALL_RED
`ifdef LIGHT_FLASH_EN
      ,
      ST_FLASH
`endif
   } ctrl_state_e;

endpackage

// File: rtl/rr_phase_select.sv
// Combinational round-robin search: first requesting phase after the active one, with wrap.
// The active phase itself is never selected.
module rr_phase_select #(
   parameter int unsigned NUM_PHASES = 4,
   parameter int unsigned PH_W       = $clog2(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] req,
   input  logic [PH_W-1:0]       active_phase,
   output logic [PH_W-1:0]       next_phase,
   output logic                  found
);

   always_comb begin
      int unsigned idx;
      idx        = 0;
      next_phase = active_phase;
      found      = 1'b0;
      for (int unsigned k = 1; k < NUM_PHASES; k++) begin
         idx = (32'(active_phase) + k) % NUM_PHASES;
         if (!found && req[PH_W'(idx)]) begin
            found      = 1'b1;
            next_phase = PH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/multiway_light_ctrl.sv
// N-phase intersection controller: demand-driven round robin, min/max green, yellow and all-red clearance.
// Macro LIGHT_FLASH_EN adds the flash_req port and the FLASH state.
module multiway_light_ctrl
   import light_pkg::*;
#(
   parameter int unsigned NUM_PHASES = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned GREEN_MIN  = 10,
   parameter int unsigned GREEN_MAX  = 40,
   parameter int unsigned YELLOW_T   = 3,
   parameter int unsigned ALLRED_T   = 2
`ifdef LIGHT_FLASH_EN
   ,
   parameter int unsigned FLASH_T    = 1
`endif
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clk_en,
   input  logic [NUM_PHASES-1:0]          car,
`ifdef LIGHT_FLASH_EN
   input  logic                           flash_req,
`endif
   output logic [LAMP_W*NUM_PHASES-1:0]   lights,
   output logic [$clog2(NUM_PHASES)-1:0]  active_phase,
   output logic                           phase_change
);

   localparam int unsigned PH_W     = $clog2(NUM_PHASES);
   localparam int unsigned LIGHTS_W = LAMP_W * NUM_PHASES;

   localparam logic [CNT_W-1:0]    G_MIN_M1   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0]    G_MAX_M1   = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0]    Y_M1       = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0]    AR_M1      = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0]    TIMER_MAX  = '1;
   localparam logic [LIGHTS_W-1:0] LIGHTS_RST = LIGHTS_W'(LAMP_GREEN);
`ifdef LIGHT_FLASH_EN
   localparam logic [CNT_W-1:0]    F_M1       = CNT_W'(FLASH_T - 1);
`endif

   ctrl_state_e           state_q, state_d;
   logic [PH_W-1:0]       active_q, active_d;
   logic [PH_W-1:0]       next_q, next_d;
   logic [CNT_W-1:0]      timer_q, timer_d;
   logic [NUM_PHASES-1:0] req_q, req_d;
   logic [LIGHTS_W-1:0]   lights_q, lights_d;
   logic                  phase_change_q, phase_change_d;
`ifdef LIGHT_FLASH_EN
   logic                  flash_off_q, flash_off_d;
   logic                  flash_toggle;
`endif

   logic [PH_W-1:0]       sel_phase;
   logic                  sel_found;

   rr_phase_select #(
      .NUM_PHASES (NUM_PHASES),
      .PH_W       (PH_W)
   ) u_rr_phase_select (
      .req          (req_q),
      .active_phase (active_q),
      .next_phase   (sel_phase),
      .found        (sel_found)
   );

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_GREEN;
         active_q       <= '0;
         next_q         <= '0;
         timer_q        <= '0;
         req_q          <= '0;
         lights_q       <= LIGHTS_RST;
         phase_change_q <= 1'b0;
`ifdef LIGHT_FLASH_EN
         flash_off_q    <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         active_q       <= active_d;
         next_q         <= next_d;
         timer_q        <= timer_d;
         req_q          <= req_d;
         lights_q       <= lights_d;
         phase_change_q <= phase_change_d;
`ifdef LIGHT_FLASH_EN
         flash_off_q    <= flash_off_d;
`endif
      end
   end

   // Next-state, phase latch and change pulse
   always_comb begin
      state_d        = state_q;
      active_d       = active_q;
      next_d         = next_q;
      phase_change_d = 1'b0;
`ifdef LIGHT_FLASH_EN
      flash_off_d    = flash_off_q;
      flash_toggle   = 1'b0;
`endif

      case (state_q)
         ST_GREEN: begin
            if (clk_en && (timer_q >= G_MIN_M1) && sel_found &&
                (!car[active_q] || (timer_q >= G_MAX_M1))) begin
               state_d = ST_YELLOW;
               next_d  = sel_phase;
            end
         end
         ST_YELLOW: begin
            if (clk_en && (timer_q == Y_M1)) state_d = ST_ALL_RED;
         end
         ST_ALL_RED: begin
            if (clk_en && (timer_q == AR_M1)) begin
               state_d        = ST_GREEN;
               active_d       = next_q;
               phase_change_d = 1'b1;
            end
         end
`ifdef LIGHT_FLASH_EN
         ST_FLASH: begin
            if (clk_en && !flash_req) begin
               state_d = ST_ALL_RED;
               next_d  = '0;
            end else if (clk_en && (timer_q == F_M1)) begin
               flash_off_d  = ~flash_off_q;
               flash_toggle = 1'b1;
            end
         end
`endif
         default: state_d = ST_GREEN;
      endcase

`ifdef LIGHT_FLASH_EN
      // Flash request overrides everything, independent of the tick
      if (flash_req && (state_q != ST_FLASH)) begin
         state_d        = ST_FLASH;
         active_d       = active_q;
         next_d         = next_q;
         phase_change_d = 1'b0;
         flash_off_d    = 1'b0;
      end
`endif
   end

   // Tick timer, cleared on each state change (and on each flash half-period)
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
`ifdef LIGHT_FLASH_EN
      end else if (flash_toggle) begin
         timer_d = '0;
`endif
      end else if (clk_en && (timer_q != TIMER_MAX)) begin
         timer_d = timer_q + CNT_W'(1);
      end
   end

   // Request latch; clearing on green entry wins over a same-cycle set
   always_comb begin
      req_d = req_q;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
         if (car[i] && !((state_q == ST_GREEN) && (active_q == PH_W'(i)))) req_d[i] = 1'b1;
      end
      if ((state_d == ST_GREEN) && (state_q != ST_GREEN)) req_d[active_d] = 1'b0;
   end

   // Lamp codes derived from the upcoming state so they move with it
   always_comb begin
      lights_d = '0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
         lights_d[i*LAMP_W +: LAMP_W] = LAMP_RED;
         if (active_d == PH_W'(i)) begin
            if (state_d == ST_GREEN)  lights_d[i*LAMP_W +: LAMP_W] = LAMP_GREEN;
            if (state_d == ST_YELLOW) lights_d[i*LAMP_W +: LAMP_W] = LAMP_YELLOW;
         end
`ifdef LIGHT_FLASH_EN
         if (state_d == ST_FLASH)
            lights_d[i*LAMP_W +: LAMP_W] = flash_off_d ? LAMP_OFF : LAMP_YELLOW;
`endif
      end
   end

   assign lights       = lights_q;
   assign active_phase = active_q;
   assign phase_change = phase_change_q;

endmodule

// File: tb/tb_multiway_light_ctrl.sv
// Directed self-checking bench for multiway_light_ctrl (3 phases, short timings).
module tb_multiway_light_ctrl;

   localparam logic [5:0] L_G0 = 6'b00_00_10;
   localparam logic [5:0] L_Y0 = 6'b00_00_01;
   localparam logic [5:0] L_G1 = 6'b00_10_00;
   localparam logic [5:0] L_Y1 = 6'b00_01_00;
   localparam logic [5:0] L_G2 = 6'b10_00_00;
   localparam logic [5:0] L_AR = 6'b00_00_00;

   logic       clk;
   logic       rst_n;
   logic       clk_en;
   logic [2:0] car;
   logic [5:0] lights;
   logic [1:0] active_phase;
   logic       phase_change;
`ifdef LIGHT_FLASH_EN
   logic       flash_req;
`endif

   int total;
   int bad;

   multiway_light_ctrl #(
      .NUM_PHASES (3),
      .CNT_W      (8),
      .GREEN_MIN  (4),
      .GREEN_MAX  (8),
      .YELLOW_T   (2),
      .ALLRED_T   (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_en       (clk_en),
      .car          (car),
`ifdef LIGHT_FLASH_EN
      .flash_req    (flash_req),
`endif
      .lights       (lights),
      .active_phase (active_phase),
      .phase_change (phase_change)
   );

   always #5 clk = ~clk;

   // After this returns we are just past the reset edge: cycle 0
   task automatic do_reset;
      rst_n  = 1'b0;
      car    = '0;
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      @(negedge clk);
      total++;
      if (lights !== L_G0) begin
         bad++; $display("FAIL reset_lights got %b want %b", lights, L_G0);
      end
      total++;
      if (active_phase !== 2'd0) begin
         bad++; $display("FAIL reset_active got %0d want 0", active_phase);
      end
      total++;
      if (phase_change !== 1'b0) begin
         bad++; $display("FAIL reset_pulse got %b want 0", phase_change);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_idle;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         total++;
         if (lights !== L_G0 || active_phase !== 2'd0 || phase_change !== 1'b0) begin
            bad++;
            $display("FAIL idle c=%0d got lights=%b act=%0d pc=%b want %b/0/0",
                     c, lights, active_phase, phase_change, L_G0);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_min_green;
      logic [5:0] exp_l;
      logic [1:0] exp_a;
      logic       exp_pc;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         car = (c == 0) ? 3'b100 : 3'b000;
         @(negedge clk);
         if (c <= 3)      exp_l = L_G0;
         else if (c <= 5) exp_l = L_Y0;
         else if (c == 6) exp_l = L_AR;
         else             exp_l = L_G2;
         exp_a  = (c >= 7) ? 2'd2 : 2'd0;
         exp_pc = (c == 7);
         total++;
         if (lights !== exp_l || active_phase !== exp_a || phase_change !== exp_pc) begin
            bad++;
            $display("FAIL min_green c=%0d got %b/%0d/%b want %b/%0d/%b",
                     c, lights, active_phase, phase_change, exp_l, exp_a, exp_pc);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_max_green;
      logic [5:0] exp_l;
      logic [1:0] exp_a;
      logic       exp_pc;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         car = (c == 0) ? 3'b011 : 3'b001;
         @(negedge clk);
         if (c <= 7)       exp_l = L_G0;
         else if (c <= 9)  exp_l = L_Y0;
         else if (c == 10) exp_l = L_AR;
         else              exp_l = L_G1;
         exp_a  = (c >= 11) ? 2'd1 : 2'd0;
         exp_pc = (c == 11);
         total++;
         if (lights !== exp_l || active_phase !== exp_a || phase_change !== exp_pc) begin
            bad++;
            $display("FAIL max_green c=%0d got %b/%0d/%b want %b/%0d/%b",
                     c, lights, active_phase, phase_change, exp_l, exp_a, exp_pc);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_car_drop;
      logic [5:0] exp_l;
      logic [1:0] exp_a;
      logic       exp_pc;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         car = {1'b0, (c == 0), (c < 5)};
         @(negedge clk);
         if (c <= 5)      exp_l = L_G0;
         else if (c <= 7) exp_l = L_Y0;
         else if (c == 8) exp_l = L_AR;
         else             exp_l = L_G1;
         exp_a  = (c >= 9) ? 2'd1 : 2'd0;
         exp_pc = (c == 9);
         total++;
         if (lights !== exp_l || active_phase !== exp_a || phase_change !== exp_pc) begin
            bad++;
            $display("FAIL car_drop c=%0d got %b/%0d/%b want %b/%0d/%b",
                     c, lights, active_phase, phase_change, exp_l, exp_a, exp_pc);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] exp_l;
      logic [1:0] exp_a;
      logic       exp_pc;
      int         pulses;
      pulses = 0;
      do_reset();
      for (int c = 0; c < 41; c++) begin
         car = (c == 0) ? 3'b110 : 3'b000;
         @(negedge clk);
         if (c <= 3)       exp_l = L_G0;
         else if (c <= 5)  exp_l = L_Y0;
         else if (c == 6)  exp_l = L_AR;
         else if (c <= 10) exp_l = L_G1;
         else if (c <= 12) exp_l = L_Y1;
         else if (c == 13) exp_l = L_AR;
         else              exp_l = L_G2;
         if (c < 7)       exp_a = 2'd0;
         else if (c < 14) exp_a = 2'd1;
         else             exp_a = 2'd2;
         exp_pc = (c == 7) || (c == 14);
         if (phase_change === 1'b1) pulses++;
         total++;
         if (lights !== exp_l || active_phase !== exp_a || phase_change !== exp_pc) begin
            bad++;
            $display("FAIL back_to_back c=%0d got %b/%0d/%b want %b/%0d/%b",
                     c, lights, active_phase, phase_change, exp_l, exp_a, exp_pc);
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (pulses != 2) begin
         bad++; $display("FAIL back_to_back_pulses got %0d want 2", pulses);
      end
   endtask

   task automatic test_clk_en;
      logic [5:0] exp_l;
      logic [1:0] exp_a;
      logic       exp_pc;
      do_reset();
      for (int c = 0; c < 36; c++) begin
         clk_en = ((c % 4) == 3);
         car    = (c == 1) ? 3'b010 : 3'b000;
         @(negedge clk);
         if (c <= 15)      exp_l = L_G0;
         else if (c <= 23) exp_l = L_Y0;
         else if (c <= 27) exp_l = L_AR;
         else              exp_l = L_G1;
         exp_a  = (c >= 28) ? 2'd1 : 2'd0;
         exp_pc = (c == 28);
         total++;
         if (lights !== exp_l || active_phase !== exp_a || phase_change !== exp_pc) begin
            bad++;
            $display("FAIL clk_en c=%0d got %b/%0d/%b want %b/%0d/%b",
                     c, lights, active_phase, phase_change, exp_l, exp_a, exp_pc);
         end
         @(posedge clk);
         #1;
      end
      clk_en = 1'b1;
   endtask

   task automatic test_reset_mid;
      logic [5:0] exp_l;
      do_reset();
      for (int c = 0; c < 36; c++) begin
         car   = (c == 0) ? 3'b100 : 3'b000;
         rst_n = (c != 4);
         @(negedge clk);
         exp_l = (c == 4) ? L_Y0 : L_G0;
         total++;
         if (lights !== exp_l || active_phase !== 2'd0 || phase_change !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid c=%0d got %b/%0d/%b want %b/0/0",
                     c, lights, active_phase, phase_change, exp_l);
         end
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      clk    = 1'b0;
      rst_n  = 1'b0;
      clk_en = 1'b1;
      car    = '0;
`ifdef LIGHT_FLASH_EN
      flash_req = 1'b0;
`endif
      total = 0;
      bad   = 0;
      test_reset();
      test_idle();
      test_min_green();
      test_max_green();
      test_car_drop();
      test_back_to_back();
      test_clk_en();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
